// File: rtl/hpss_pkg.sv
// Shared types and constants for the HPSS STFT front end.
//   state_t       : framer FSM states {FILL, EMIT, HOP}
//   WIN_WIDTH_DEF : default window coefficient width
//   FRAME_CNT_W   : width of the emitted-frame counter
//   round_const() : round-half-up constant for a given coefficient width
package hpss_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    HOP  = 2'd2
  } state_t;

  localparam int unsigned WIN_WIDTH_DEF = 8;
  localparam int unsigned FRAME_CNT_W   = 16;

  // Half an LSB of the product scaled by 2^ww.
  function automatic int unsigned round_const(input int unsigned ww);
    return 32'd1 << (ww - 32'd1);
  endfunction

endpackage

// File: rtl/hpss_window_rom.sv
// Periodic Hann window coefficient ROM with a 1-cycle registered read.
//   clk  : clock
//   en   : read enable (holds coef when low)
//   addr : sample index within the frame
//   coef : unsigned window coefficient, round((2^WIN_WIDTH-1)*0.5*(1-cos(2*pi*k/FRAME_LEN)))
module hpss_window_rom #(
  parameter int unsigned FRAME_LEN = 512,
  parameter int unsigned WIN_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic [$clog2(FRAME_LEN)-1:0] addr,
  output logic [WIN_WIDTH-1:0]         coef
);

  localparam real PI = 3.14159265358979323846;

  // The small bias keeps exact .5 points (e.g. k=FRAME_LEN/4) from rounding down
  // because cos() returns a value a hair above zero.
  function automatic logic [WIN_WIDTH-1:0] hann(input int unsigned k);
    real full;
    real v;
    full = real'((32'd1 << WIN_WIDTH) - 32'd1);
    v    = full * 0.5 * (1.0 - $cos(2.0 * PI * real'(k) / real'(FRAME_LEN)));
    return WIN_WIDTH'($rtoi(v + 0.5 + 1.0e-9));
  endfunction

  logic [WIN_WIDTH-1:0] table_c [FRAME_LEN];

  // Table entries are constant expressions of the genvar only.
  for (genvar k = 0; k < int'(FRAME_LEN); k++) begin : g_tab
    assign table_c[k] = hann(k);
  end

  // Registered read, aligned with the buffer RAM read.
  always_ff @(posedge clk) begin
    if (en) begin
      coef <= table_c[addr];
    end
  end

endmodule

// File: rtl/hpss_stft_framer.sv
// STFT framer: buffers a mono stream, cuts FRAME_LEN-sample frames every HOP_LEN
// samples, applies a periodic Hann window and streams each frame oldest-first.
// Optional feature macro: HPSS_FRAMER_BYPASS_EN adds input win_bypass; when high
// the raw sample is emitted with the same latency and handshake.
// Ports:
//   clk, rst (sync, active-high), flush (1-cycle pulse, restarts in FILL)
//   s_valid/s_ready/s_data                 : input sample stream
//   m_valid/m_ready/m_data                 : windowed output stream
//   m_index, m_first, m_last               : position of m_data within the frame
//   frame_cnt                              : frames fully emitted since reset/flush
module hpss_stft_framer
  import hpss_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAME_LEN  = 512,
  parameter int unsigned HOP_LEN    = 256,
  parameter int unsigned WIN_WIDTH  = WIN_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = $clog2(FRAME_LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
`ifdef HPSS_FRAMER_BYPASS_EN
  input  logic                   win_bypass,
`endif
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [ADDR_WIDTH-1:0]  m_index,
  output logic                   m_first,
  output logic                   m_last,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned PW = DATA_WIDTH + WIN_WIDTH + 1;

  if (HOP_LEN == 0 || HOP_LEN > FRAME_LEN) begin : g_bad_hop
    $error("hpss_stft_framer: HOP_LEN must be in 1..FRAME_LEN");
  end
  if (FRAME_LEN < 4 || (FRAME_LEN & (FRAME_LEN - 1)) != 0) begin : g_bad_frame
    $error("hpss_stft_framer: FRAME_LEN must be a power of 2, >= 4");
  end

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [CW-1:0]           fill_cnt;
  logic [CW-1:0]           rd_cnt;
  logic [DATA_WIDTH-1:0]   ram [FRAME_LEN];
  logic [DATA_WIDTH-1:0]   ram_q;
  logic [WIN_WIDTH-1:0]    coef;
  logic                    v1;
  logic [ADDR_WIDTH-1:0]   idx1;

  logic                    clr_c;
  logic                    wr_fire_c;
  logic                    fill_done_c;
  logic                    advance_c;
  logic                    issue_c;
  logic                    last_fire_c;
  logic [ADDR_WIDTH-1:0]   rd_ptr_c;
  logic signed [PW-1:0]    x_ext_c;
  logic signed [PW-1:0]    w_ext_c;
  logic signed [PW-1:0]    prod_c;
  logic [DATA_WIDTH-1:0]   win_data_c;
  logic [DATA_WIDTH-1:0]   out_c;

  assign clr_c       = rst || flush;
  assign wr_fire_c   = s_valid && s_ready && !clr_c;
  assign fill_done_c = wr_fire_c &&
                       (fill_cnt == ((state == FILL) ? CW'(FRAME_LEN - 1) : CW'(HOP_LEN - 1)));
  assign advance_c   = !m_valid || m_ready;
  assign issue_c     = (state == EMIT) && (rd_cnt != CW'(FRAME_LEN)) && advance_c;
  assign last_fire_c = m_valid && m_ready && m_last;
  // wr_ptr is frozen during EMIT and points at the oldest sample.
  assign rd_ptr_c    = wr_ptr + rd_cnt[ADDR_WIDTH-1:0];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (clr_c) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (fill_done_c) state_nxt = EMIT;
      EMIT:    if (last_fire_c) state_nxt = HOP;
      HOP:     if (fill_done_c) state_nxt = EMIT;
      default: state_nxt = FILL;
    endcase
  end

  // Pointers, counters and the registered input ready.
  always_ff @(posedge clk) begin
    if (clr_c) begin
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      rd_cnt    <= '0;
      s_ready   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      s_ready <= (state_nxt != EMIT);
      if (wr_fire_c) begin
        wr_ptr   <= wr_ptr + ADDR_WIDTH'(1);
        fill_cnt <= fill_done_c ? '0 : fill_cnt + CW'(1);
      end
      if (issue_c) begin
        rd_cnt <= rd_cnt + CW'(1);
      end else if (last_fire_c) begin
        rd_cnt <= '0;
      end
      if (last_fire_c) begin
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end
    end
  end

  // Circular sample buffer: write port.
  always_ff @(posedge clk) begin
    if (wr_fire_c) begin
      ram[wr_ptr] <= s_data;
    end
  end

  // Circular sample buffer: registered read, stalls with the pipeline.
  always_ff @(posedge clk) begin
    if (advance_c) begin
      ram_q <= ram[rd_ptr_c];
    end
  end

  hpss_window_rom #(
    .FRAME_LEN (FRAME_LEN),
    .WIN_WIDTH (WIN_WIDTH)
  ) u_rom (
    .clk  (clk),
    .en   (advance_c),
    .addr (rd_cnt[ADDR_WIDTH-1:0]),
    .coef (coef)
  );

  // Signed sample times zero-extended coefficient, rounded half up.
  assign x_ext_c    = PW'($signed(ram_q));
  assign w_ext_c    = PW'(coef);
  assign prod_c     = x_ext_c * w_ext_c + PW'(round_const(WIN_WIDTH));
  assign win_data_c = DATA_WIDTH'(prod_c >>> WIN_WIDTH);

`ifdef HPSS_FRAMER_BYPASS_EN
  logic byp1;

  // Bypass select travels with its sample through stage 1.
  always_ff @(posedge clk) begin
    if (clr_c) begin
      byp1 <= 1'b0;
    end else if (advance_c) begin
      byp1 <= win_bypass;
    end
  end

  assign out_c = byp1 ? ram_q : win_data_c;
`else
  assign out_c = win_data_c;
`endif

  // Stage 1 control: valid and index alongside the RAM/ROM read.
  always_ff @(posedge clk) begin
    if (clr_c) begin
      v1   <= 1'b0;
      idx1 <= '0;
    end else if (advance_c) begin
      v1   <= issue_c;
      idx1 <= rd_cnt[ADDR_WIDTH-1:0];
    end
  end

  // Stage 2: multiply/round into the output registers.
  always_ff @(posedge clk) begin
    if (clr_c) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_index <= '0;
      m_first <= 1'b0;
      m_last  <= 1'b0;
    end else if (advance_c) begin
      m_valid <= v1;
      m_data  <= out_c;
      m_index <= idx1;
      m_first <= v1 && (idx1 == '0);
      m_last  <= v1 && (idx1 == ADDR_WIDTH'(FRAME_LEN - 1));
    end
  end

endmodule
